hvac_zone_scheduler: RTL and testbench

HVAC_ZONE_SCHEDULER -- requirements
Module: hvac_zone_scheduler

---
 rtl/hvac_pkg.sv | 35 +++
 rtl/zone_rr_pick.sv | 27 ++
 rtl/hvac_zone_scheduler.sv | 144 ++++++++++++++
 tb/tb_hvac_zone_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hvac_pkg.sv
// Shared types and constants for the HVAC zone scheduler.
package hvac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2,
    ST_LOCK   = 2'd3
  } state_t;

  localparam int NUM_ZONES = 4;
  localparam int SP_W      = 7;

  localparam logic [SP_W-1:0] SP_MIN   = 7'd16;
  localparam logic [SP_W-1:0] SP_MAX   = 7'd30;
  localparam logic [SP_W-1:0] SP_RESET = 7'd22;

  // Keep a requested setpoint inside the range the AC controller accepts.
  function automatic logic [SP_W-1:0] clamp_sp(input logic [SP_W-1:0] sp);
    if (sp < SP_MIN) return SP_MIN;
    if (sp > SP_MAX) return SP_MAX;
    return sp;
  endfunction

  // Convert a one-hot zone vector into its zone index.
  function automatic logic [1:0] onehot_to_idx(input logic [NUM_ZONES-1:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/zone_rr_pick.sv
// Combinational round-robin picker: first requesting zone after 'last', with wrap.
module zone_rr_pick
  import hvac_pkg::*;
(
  input  logic [NUM_ZONES-1:0] req,
  input  logic [1:0]           last,
  output logic [NUM_ZONES-1:0] grant,
  output logic                 valid
);

  logic [1:0] idx;

  // Scan last+1, last+2, ... last+4 and take the first zone that requests.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_ZONES; i++) begin
      idx = last + 2'(i);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hvac_zone_scheduler.sv
// Time-slices a single compressor across four zones with minimum run,
// damper settle and anti-short-cycle lockout, all counted in tick units.
module hvac_zone_scheduler
  import hvac_pkg::*;
#(
  parameter int MIN_RUN = 4,
  parameter int SLICE   = 16,
  parameter int LOCKOUT = 8,
  parameter int SWITCH  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [NUM_ZONES-1:0]      zone_req,
  input  logic [NUM_ZONES*SP_W-1:0] zone_setpoint,
  output logic [NUM_ZONES-1:0]      zone_grant,
  output logic                      ac_enable,
  output logic [SP_W-1:0]           setpoint_out,
  output logic [1:0]                state_out
);

  localparam logic [7:0] MIN_RUN_C = 8'(MIN_RUN);
  localparam logic [7:0] SLICE_C   = 8'(SLICE);
  localparam logic [7:0] LOCKOUT_C = 8'(LOCKOUT);
  localparam logic [7:0] SWITCH_C  = 8'(SWITCH);

  state_t                 state;
  state_t                 next_state;
  logic [7:0]             cnt;
  logic [NUM_ZONES-1:0]   grant_q;
  logic [1:0]             last_granted;
  logic [SP_W-1:0]        sp_q;

  logic [NUM_ZONES-1:0]   pick_grant;
  logic                   pick_valid;
  logic                   cnt_clear;
  logic                   load_grant;
  logic                   any_req;
  logic                   granted_req;
  logic                   other_req;

  zone_rr_pick u_pick (
    .req   (zone_req),
    .last  (last_granted),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign any_req     = |zone_req;
  assign granted_req = |(zone_req & grant_q);
  assign other_req   = |(zone_req & ~grant_q);

  // State register; reset lands directly in IDLE, skipping the lockout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; conditions look at the registered cnt, and any
  // transition (or slice restart) clears cnt so a coincident tick is absorbed.
  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    load_grant = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          next_state = ST_RUN;
          cnt_clear  = 1'b1;
          load_grant = 1'b1;
        end
      end
      ST_RUN: begin
        if (cnt >= MIN_RUN_C) begin
          if (!any_req) begin
            next_state = ST_LOCK;
            cnt_clear  = 1'b1;
          end else if (other_req && (!granted_req || cnt >= SLICE_C)) begin
            next_state = ST_SWITCH;
            cnt_clear  = 1'b1;
          end else if (cnt >= SLICE_C) begin
            cnt_clear  = 1'b1;
          end
        end
      end
      ST_SWITCH: begin
        if (cnt >= SWITCH_C) begin
          cnt_clear = 1'b1;
          if (pick_valid) begin
            next_state = ST_RUN;
            load_grant = 1'b1;
          end else begin
            next_state = ST_LOCK;
          end
        end
      end
      ST_LOCK: begin
        if (cnt >= LOCKOUT_C) begin
          next_state = ST_IDLE;
          cnt_clear  = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
        cnt_clear  = 1'b1;
      end
    endcase
  end

  // Tick counter, grant/round-robin history and the clamped setpoint register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      grant_q      <= '0;
      last_granted <= 2'd3;
      sp_q         <= SP_RESET;
    end else begin
      if (cnt_clear) begin
        cnt <= '0;
      end else if (tick && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (load_grant) begin
        grant_q      <= pick_grant;
        last_granted <= onehot_to_idx(pick_grant);
      end
      if (state == ST_RUN) begin
        sp_q <= clamp_sp(zone_setpoint[SP_W*last_granted +: SP_W]);
      end
    end
  end

  // Outputs decoded from state; dampers only open in RUN, compressor runs in RUN and SWITCH.
  always_comb begin
    zone_grant   = (state == ST_RUN) ? grant_q : '0;
    ac_enable    = (state == ST_RUN) || (state == ST_SWITCH);
    state_out    = state;
    setpoint_out = sp_q;
  end

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Directed self-checking bench for hvac_zone_scheduler with default parameters.
module tb_hvac_zone_scheduler;

  logic        clk;
  logic        reset;
  logic        tick;
  logic [3:0]  zone_req;
  logic [27:0] zone_setpoint;
  logic [3:0]  zone_grant;
  logic        ac_enable;
  logic [6:0]  setpoint_out;
  logic [1:0]  state_out;

  int n_compared;
  int n_mismatched;

  hvac_zone_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .zone_req      (zone_req),
    .zone_setpoint (zone_setpoint),
    .zone_grant    (zone_grant),
    .ac_enable     (ac_enable),
    .setpoint_out  (setpoint_out),
    .state_out     (state_out)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One clock edge with the given tick level; returns at the following negedge.
  task automatic step(input logic t);
    tick = t;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    zone_req = 4'b1111;
    step(1'b1);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd0, 4'b0000, 1'b0}) begin
      $display("[TB] FAIL reset_ctrl: got %b required %b", {state_out, zone_grant, ac_enable}, 7'b00_0000_0);
      n_mismatched++;
    end
    n_compared++;
    if (setpoint_out !== 7'd22) begin
      $display("[TB] FAIL reset_sp: got %0d required 22", setpoint_out);
      n_mismatched++;
    end
    zone_req = 4'b0000;
    reset = 1'b0;
    step(1'b0);
    n_compared++;
    if (state_out !== 2'd0) begin
      $display("[TB] FAIL idle_no_req: got %0d required 0", state_out);
      n_mismatched++;
    end
  endtask

  task automatic test_basic_run();
    zone_req = 4'b0001;
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd1, 4'b0001, 1'b1}) begin
      $display("[TB] FAIL run_entry: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd1, 4'b0001, 1'b1});
      n_mismatched++;
    end
    n_compared++;
    if (setpoint_out !== 7'd22) begin
      $display("[TB] FAIL sp_latency: got %0d required 22", setpoint_out);
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if (setpoint_out !== 7'd24) begin
      $display("[TB] FAIL sp_zone0: got %0d required 24", setpoint_out);
      n_mismatched++;
    end
  endtask

  task automatic test_min_run_lock();
    step(1'b1);
    zone_req = 4'b0000;
    ticks(2);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd1, 4'b0001, 1'b1}) begin
      $display("[TB] FAIL min_run_hold3: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd1, 4'b0001, 1'b1});
      n_mismatched++;
    end
    ticks(1);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd1, 4'b0001, 1'b1}) begin
      $display("[TB] FAIL min_run_hold4: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd1, 4'b0001, 1'b1});
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd3, 4'b0000, 1'b0}) begin
      $display("[TB] FAIL lock_entry: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd3, 4'b0000, 1'b0});
      n_mismatched++;
    end
    ticks(8);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd3, 4'b0000, 1'b0}) begin
      $display("[TB] FAIL lock_hold8: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd3, 4'b0000, 1'b0});
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if ({state_out, ac_enable} !== {2'd0, 1'b0}) begin
      $display("[TB] FAIL lock_exit: got %b required %b", {state_out, ac_enable}, {2'd0, 1'b0});
      n_mismatched++;
    end
  endtask

  task automatic test_setpoint_clamp();
    zone_req = 4'b0010;
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant} !== {2'd1, 4'b0010}) begin
      $display("[TB] FAIL rr_after0: got %b required %b", {state_out, zone_grant}, {2'd1, 4'b0010});
      n_mismatched++;
    end
    zone_setpoint[13:7] = 7'd40;
    step(1'b0);
    n_compared++;
    if (setpoint_out !== 7'd30) begin
      $display("[TB] FAIL clamp_high: got %0d required 30", setpoint_out);
      n_mismatched++;
    end
    zone_setpoint[13:7] = 7'd30;
    step(1'b0);
    n_compared++;
    if (setpoint_out !== 7'd30) begin
      $display("[TB] FAIL clamp_edge30: got %0d required 30", setpoint_out);
      n_mismatched++;
    end
    zone_setpoint[13:7] = 7'd5;
    step(1'b0);
    n_compared++;
    if (setpoint_out !== 7'd16) begin
      $display("[TB] FAIL clamp_low: got %0d required 16", setpoint_out);
      n_mismatched++;
    end
    zone_req = 4'b0000;
    ticks(4);
    step(1'b0);
    n_compared++;
    if (state_out !== 2'd3) begin
      $display("[TB] FAIL z1_lock: got %0d required 3", state_out);
      n_mismatched++;
    end
    zone_setpoint[13:7] = 7'd25;
    step(1'b0);
    n_compared++;
    if (setpoint_out !== 7'd16) begin
      $display("[TB] FAIL sp_hold_lock: got %0d required 16", setpoint_out);
      n_mismatched++;
    end
  endtask

  task automatic test_lock_ignores_req();
    ticks(3);
    zone_req = 4'b1111;
    ticks(4);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd3, 4'b0000, 1'b0}) begin
      $display("[TB] FAIL lock_req_cnt7: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd3, 4'b0000, 1'b0});
      n_mismatched++;
    end
    ticks(1);
    n_compared++;
    if (state_out !== 2'd3) begin
      $display("[TB] FAIL lock_req_cnt8: got %0d required 3", state_out);
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if (state_out !== 2'd0) begin
      $display("[TB] FAIL lock_req_idle: got %0d required 0", state_out);
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd1, 4'b0100, 1'b1}) begin
      $display("[TB] FAIL lock_req_rr: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd1, 4'b0100, 1'b1});
      n_mismatched++;
    end
  endtask

  task automatic test_reset_mid_run();
    step(1'b0);
    n_compared++;
    if (setpoint_out !== 7'd27) begin
      $display("[TB] FAIL sp_zone2: got %0d required 27", setpoint_out);
      n_mismatched++;
    end
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    n_compared++;
    if ({state_out, zone_grant, ac_enable, setpoint_out} !== {2'd0, 4'b0000, 1'b0, 7'd22}) begin
      $display("[TB] FAIL mid_run_reset: got %b required %b", {state_out, zone_grant, ac_enable, setpoint_out}, {2'd0, 4'b0000, 1'b0, 7'd22});
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd1, 4'b0001, 1'b1}) begin
      $display("[TB] FAIL post_reset_run: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd1, 4'b0001, 1'b1});
      n_mismatched++;
    end
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    zone_req = 4'b0101;
    step(1'b0);
    ticks(16);
    n_compared++;
    if ({state_out, zone_grant} !== {2'd1, 4'b0001}) begin
      $display("[TB] FAIL slice_z0: got %b required %b", {state_out, zone_grant}, {2'd1, 4'b0001});
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd2, 4'b0000, 1'b1}) begin
      $display("[TB] FAIL switch_a: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd2, 4'b0000, 1'b1});
      n_mismatched++;
    end
    ticks(2);
    n_compared++;
    if ({state_out, ac_enable} !== {2'd2, 1'b1}) begin
      $display("[TB] FAIL switch_a_hold: got %b required %b", {state_out, ac_enable}, {2'd2, 1'b1});
      n_mismatched++;
    end
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant} !== {2'd1, 4'b0100}) begin
      $display("[TB] FAIL grant_z2: got %b required %b", {state_out, zone_grant}, {2'd1, 4'b0100});
      n_mismatched++;
    end
    ticks(16);
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant} !== {2'd2, 4'b0000}) begin
      $display("[TB] FAIL switch_b: got %b required %b", {state_out, zone_grant}, {2'd2, 4'b0000});
      n_mismatched++;
    end
    ticks(2);
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant} !== {2'd1, 4'b0001}) begin
      $display("[TB] FAIL grant_z0_again: got %b required %b", {state_out, zone_grant}, {2'd1, 4'b0001});
      n_mismatched++;
    end
  endtask

  task automatic test_slice_restart();
    zone_req = 4'b0001;
    ticks(16);
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant} !== {2'd1, 4'b0001}) begin
      $display("[TB] FAIL slice_restart: got %b required %b", {state_out, zone_grant}, {2'd1, 4'b0001});
      n_mismatched++;
    end
    zone_req = 4'b0011;
    ticks(15);
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant} !== {2'd1, 4'b0001}) begin
      $display("[TB] FAIL restart_cnt15: got %b required %b", {state_out, zone_grant}, {2'd1, 4'b0001});
      n_mismatched++;
    end
    ticks(1);
    step(1'b0);
    n_compared++;
    if (state_out !== 2'd2) begin
      $display("[TB] FAIL restart_switch: got %0d required 2", state_out);
      n_mismatched++;
    end
    zone_req = 4'b0000;
    ticks(2);
    step(1'b0);
    n_compared++;
    if ({state_out, zone_grant, ac_enable} !== {2'd3, 4'b0000, 1'b0}) begin
      $display("[TB] FAIL switch_to_lock: got %b required %b", {state_out, zone_grant, ac_enable}, {2'd3, 4'b0000, 1'b0});
      n_mismatched++;
    end
  endtask

  // Scenario sequence; each task starts and ends on a falling edge.
  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b1;
    tick          = 1'b0;
    zone_req      = 4'b0000;
    zone_setpoint = {7'd18, 7'd27, 7'd21, 7'd24};
    @(negedge clk);
    test_reset();
    test_basic_run();
    test_min_run_lock();
    test_setpoint_clamp();
    test_lock_ignores_req();
    test_reset_mid_run();
    test_back_to_back();
    test_slice_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
